// File: rtl/rgmii_cal_pkg.sv
// RGMII receive delay calibration: shared types and constants.
// Imported by the calibration top level and the preamble checker.
package rgmii_cal_pkg;

  localparam int TAP_W    = 5;
  localparam int NUM_TAPS = 32;

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SET_TAP,
    ST_SETTLE,
    ST_ARM,
    ST_SAMPLE,
    ST_EVAL,
    ST_CENTER,
    ST_DONE,
    ST_FAIL
  } cal_state_e;

  // Sweep is busy everywhere except the three resting states.
  function automatic logic is_busy(input cal_state_e s);
    return !(s == ST_IDLE || s == ST_DONE || s == ST_FAIL);
  endfunction

endpackage

// File: rtl/rgmii_pre_chk.sv
// Scores each GMII frame's preamble/SFD while enabled.
// Emits one-cycle frame_good / frame_bad pulses.
module rgmii_pre_chk
  import rgmii_cal_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dv,
  input  logic [7:0] rxd,
  output logic       frame_good,
  output logic       frame_bad
);

  logic       dv_q, dv_d;
  logic       act_q, act_d;
  logic [2:0] cnt_q, cnt_d;
  logic       good_q, good_d;
  logic       bad_q, bad_d;

  // Frame starts on a dv rise; score settles at SFD or first error.
  always_comb begin
    dv_d   = dv;
    act_d  = act_q;
    cnt_d  = cnt_q;
    good_d = 1'b0;
    bad_d  = 1'b0;
    if (!en) begin
      act_d = 1'b0;
      cnt_d = 3'd0;
    end else if (dv && !dv_q) begin
      if (rxd == PRE_BYTE) begin
        act_d = 1'b1;
        cnt_d = 3'd1;
      end else begin
        bad_d = 1'b1;
        act_d = 1'b0;
        cnt_d = 3'd0;
      end
    end else if (act_q) begin
      if (!dv) begin
        bad_d = 1'b1;
        act_d = 1'b0;
      end else if (rxd == PRE_BYTE) begin
        if (cnt_q == 3'd7) begin
          bad_d = 1'b1;
          act_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end else if (rxd == SFD_BYTE) begin
        good_d = 1'b1;
        act_d  = 1'b0;
      end else begin
        bad_d = 1'b1;
        act_d = 1'b0;
      end
    end
  end

  // Checker state and registered result pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      dv_q   <= 1'b0;
      act_q  <= 1'b0;
      cnt_q  <= 3'd0;
      good_q <= 1'b0;
      bad_q  <= 1'b0;
    end else begin
      dv_q   <= dv_d;
      act_q  <= act_d;
      cnt_q  <= cnt_d;
      good_q <= good_d;
      bad_q  <= bad_d;
    end
  end

  assign frame_good = good_q;
  assign frame_bad  = bad_q;

endmodule

// File: rtl/rgmii_rx_dly_cal.sv
// Sweeps the RGMII RX input delay across all taps, finds the widest
// passing window and parks the tap at its centre.
module rgmii_rx_dly_cal
  import rgmii_cal_pkg::*;
#(
  parameter int FRAMES_PER_TAP = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int MIN_WINDOW     = 3,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int DEFAULT_TAP    = 0
) (
  input  logic             gmii_rx_clk,
  input  logic             rst,
  input  logic             cal_start,
  input  logic             gmii_rx_dv,
  input  logic [7:0]       gmii_rxd,
  output logic [TAP_W-1:0] in_dly,
  output logic             cal_busy,
  output logic             cal_done,
  output logic             cal_fail,
  output logic [TAP_W-1:0] win_lo,
  output logic [TAP_W-1:0] win_hi
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int FW = $clog2(FRAMES_PER_TAP + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TAP_W-1:0] DEF_TAP = TAP_W'(DEFAULT_TAP);

  cal_state_e       state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [FW-1:0]    frame_q, frame_d;
  logic [WW-1:0]    wd_q, wd_d;
  logic             pass_q, pass_d;
  logic [TAP_W-1:0] cur_start_q, cur_start_d;
  logic [5:0]       cur_len_q, cur_len_d;
  logic [TAP_W-1:0] best_start_q, best_start_d;
  logic [5:0]       best_len_q, best_len_d;
  logic [TAP_W-1:0] in_dly_q, in_dly_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic [TAP_W-1:0] lo_q, lo_d;
  logic [TAP_W-1:0] hi_q, hi_d;

  logic [5:0]       nl;
  logic [TAP_W-1:0] ns;
  logic             frame_good;
  logic             frame_bad;
  logic             chk_en;

  assign chk_en = (state_q == ST_SAMPLE);

  rgmii_pre_chk u_pre_chk (
    .clk        (gmii_rx_clk),
    .rst        (rst),
    .en         (chk_en),
    .dv         (gmii_rx_dv),
    .rxd        (gmii_rxd),
    .frame_good (frame_good),
    .frame_bad  (frame_bad)
  );

  // Sweep sequencer, window tracking and output computation.
  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    settle_d     = settle_q;
    frame_d      = frame_q;
    wd_d         = wd_q;
    pass_d       = pass_q;
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    in_dly_d     = in_dly_q;
    done_d       = done_q;
    fail_d       = fail_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    nl           = cur_len_q;
    ns           = cur_start_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (cal_start) begin
          done_d       = 1'b0;
          fail_d       = 1'b0;
          cur_start_d  = '0;
          cur_len_d    = '0;
          best_start_d = '0;
          best_len_d   = '0;
          tap_d        = '0;
          state_d      = ST_SET_TAP;
        end
      end
      ST_SET_TAP: begin
        in_dly_d = tap_q;
        settle_d = '0;
        frame_d  = '0;
        wd_d     = '0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1))
          state_d = ST_ARM;
        else
          settle_d = settle_q + 1'b1;
      end
      ST_ARM: begin
        if (!gmii_rx_dv)
          state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        wd_d = wd_q + 1'b1;
        if (frame_bad) begin
          pass_d  = 1'b0;
          state_d = ST_EVAL;
        end else if (frame_good &&
                     frame_q == FW'(FRAMES_PER_TAP - 1)) begin
          pass_d  = 1'b1;
          state_d = ST_EVAL;
        end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
          fail_d   = 1'b1;
          in_dly_d = DEF_TAP;
          lo_d     = '0;
          hi_d     = '0;
          state_d  = ST_FAIL;
        end else if (frame_good) begin
          frame_d = frame_q + 1'b1;
        end
      end
      ST_EVAL: begin
        if (pass_q) begin
          if (cur_len_q == 6'd0)
            ns = tap_q;
          nl = cur_len_q + 6'd1;
        end else begin
          nl = 6'd0;
        end
        cur_start_d = ns;
        cur_len_d   = nl;
        // Strictly greater: ties keep the lower window.
        if (nl > best_len_q) begin
          best_start_d = ns;
          best_len_d   = nl;
        end
        if (tap_q != LAST_TAP) begin
          tap_d   = tap_q + 1'b1;
          state_d = ST_SET_TAP;
        end else begin
          state_d = ST_CENTER;
        end
      end
      ST_CENTER: begin
        if (best_len_q >= 6'(MIN_WINDOW)) begin
          in_dly_d = TAP_W'({1'b0, best_start_q} +
                            ((best_len_q - 6'd1) >> 1));
          lo_d     = best_start_q;
          hi_d     = TAP_W'({1'b0, best_start_q} +
                            best_len_q - 6'd1);
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end else begin
          fail_d   = 1'b1;
          in_dly_d = DEF_TAP;
          lo_d     = '0;
          hi_d     = '0;
          state_d  = ST_FAIL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = is_busy(state_d);
  end

  // State, counters, trackers and registered outputs.
  always_ff @(posedge gmii_rx_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tap_q        <= '0;
      settle_q     <= '0;
      frame_q      <= '0;
      wd_q         <= '0;
      pass_q       <= 1'b0;
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      in_dly_q     <= DEF_TAP;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      lo_q         <= '0;
      hi_q         <= '0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      settle_q     <= settle_d;
      frame_q      <= frame_d;
      wd_q         <= wd_d;
      pass_q       <= pass_d;
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      in_dly_q     <= in_dly_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
    end
  end

  assign in_dly   = in_dly_q;
  assign cal_busy = busy_q;
  assign cal_done = done_q;
  assign cal_fail = fail_q;
  assign win_lo   = lo_q;
  assign win_hi   = hi_q;

endmodule

// File: tb/tb_rgmii_rx_dly_cal.sv
// Directed bench for rgmii_rx_dly_cal with a tap-dependent eye model.
// Frames are good only when the current tap is inside pass_mask.
module tb_rgmii_rx_dly_cal;
  import rgmii_cal_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cal_start;
  logic       dv;
  logic [7:0] rxd;
  logic [4:0] in_dly;
  logic       cal_busy;
  logic       cal_done;
  logic       cal_fail;
  logic [4:0] win_lo;
  logic [4:0] win_hi;

  int checks = 0;
  int failures = 0;
  int gmode = 0;
  int seg_cnt = 0;
  logic [31:0] pass_mask = 32'h0;

  always #5 clk = ~clk;

  rgmii_rx_dly_cal #(
    .FRAMES_PER_TAP (4),
    .SETTLE_CYCLES  (16),
    .MIN_WINDOW     (3),
    .TIMEOUT_CYCLES (2000),
    .DEFAULT_TAP    (0)
  ) dut (
    .gmii_rx_clk (clk),
    .rst         (rst),
    .cal_start   (cal_start),
    .gmii_rx_dv  (dv),
    .gmii_rxd    (rxd),
    .in_dly      (in_dly),
    .cal_busy    (cal_busy),
    .cal_done    (cal_done),
    .cal_fail    (cal_fail),
    .win_lo      (win_lo),
    .win_hi      (win_hi)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic put(input logic v, input logic [7:0] b);
    dv  = v;
    rxd = b;
    @(negedge clk);
  endtask

  task automatic frame(input bit good);
    put(1'b1, 8'h55);
    put(1'b1, 8'h55);
    put(1'b1, good ? 8'h55 : 8'h3C);
    repeat (4) put(1'b1, 8'h55);
    put(1'b1, 8'hD5);
    put(1'b1, 8'h11);
    put(1'b1, 8'h22);
    put(1'b1, 8'h33);
    put(1'b1, 8'h44);
    repeat (4) put(1'b0, 8'h00);
  endtask

  // Counts tap programming events for the straddling-frame mode.
  always @(negedge clk)
    if (dut.state_q == ST_SET_TAP) seg_cnt <= seg_cnt + 1;

  // Traffic generator: 1 = eye model, 2 = frame straddling ARM.
  initial begin : gen
    int seen;
    seen = 0;
    dv = 1'b0;
    rxd = 8'h00;
    @(negedge clk);
    forever begin
      if (gmode == 1) begin
        seen = seg_cnt;
        frame(pass_mask[in_dly]);
      end else if (gmode == 2) begin
        if (seg_cnt != seen) begin
          seen = seg_cnt;
          repeat (30) put(1'b1, 8'h00);
          repeat (2) put(1'b0, 8'h00);
          repeat (4) frame(1'b1);
        end else begin
          put(1'b0, 8'h00);
        end
      end else begin
        seen = seg_cnt;
        put(1'b0, 8'h00);
      end
    end
  end

  task automatic run_cal(input string tag);
    int n;
    @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    check({tag, "_busy"}, cal_busy, 1);
    n = 0;
    while (cal_busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_end"}, cal_busy, 0);
  endtask

  task automatic wait_tap(input logic [4:0] t, input bit smp);
    int n;
    n = 0;
    while (!(in_dly == t &&
             (!smp || dut.state_q == ST_SAMPLE)) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("wait_tap", in_dly, t);
  endtask

  initial begin
    rst = 1'b1;
    cal_start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dly", in_dly, 0);
    check("rst_busy", cal_busy, 0);
    check("rst_done", cal_done, 0);
    check("rst_fail", cal_fail, 0);
    check("rst_lo", win_lo, 0);
    check("rst_hi", win_hi, 0);
    rst = 1'b0;

    pass_mask = 32'h0007FC00;
    gmode = 1;
    run_cal("eye10_18");
    check("eye_done", cal_done, 1);
    check("eye_fail", cal_fail, 0);
    check("eye_dly", in_dly, 14);
    check("eye_lo", win_lo, 10);
    check("eye_hi", win_hi, 18);

    pass_mask = 32'h0FF00038;
    run_cal("two_win");
    check("two_done", cal_done, 1);
    check("two_dly", in_dly, 23);
    check("two_lo", win_lo, 20);
    check("two_hi", win_hi, 27);

    pass_mask = 32'h0000F03C;
    run_cal("tie");
    check("tie_dly", in_dly, 3);
    check("tie_lo", win_lo, 2);
    check("tie_hi", win_hi, 5);

    pass_mask = 32'hC0000000;
    run_cal("narrow");
    check("nar_fail", cal_fail, 1);
    check("nar_done", cal_done, 0);
    check("nar_dly", in_dly, 0);
    check("nar_hi", win_hi, 0);

    gmode = 2;
    run_cal("straddle");
    check("str_done", cal_done, 1);
    check("str_fail", cal_fail, 0);
    check("str_dly", in_dly, 15);
    check("str_lo", win_lo, 0);
    check("str_hi", win_hi, 31);

    gmode = 0;
    run_cal("timeout");
    check("to_fail", cal_fail, 1);
    check("to_done", cal_done, 0);
    check("to_dly", in_dly, 0);

    pass_mask = 32'h0007FC00;
    gmode = 1;
    @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    wait_tap(5'd5, 1'b0);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    repeat (3) @(negedge clk);
    check("ign_dly", in_dly, 5);
    check("ign_busy", cal_busy, 1);
    begin
      int n;
      n = 0;
      while (cal_busy && n < 20000) begin
        @(negedge clk);
        n++;
      end
    end
    check("ign_end", cal_busy, 0);
    check("ign_res", in_dly, 14);
    check("ign_done", cal_done, 1);

    pass_mask = 32'hFFFFFFFF;
    @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    wait_tap(5'd7, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_dly", in_dly, 0);
    check("mrst_busy", cal_busy, 0);
    check("mrst_done", cal_done, 0);
    check("mrst_lo", win_lo, 0);
    check("mrst_hi", win_hi, 0);
    rst = 1'b0;
    gmode = 0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
